// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - circular commit trace capture with PC trigger, post-trigger window and streamed readout
module commit_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            arm,
    input  logic [XLEN-1:0] trig_pc,
    input  logic [AW-1:0]   post_cnt,
    input  logic            cap_valid,
    input  logic [XLEN-1:0] cap_pc,
    input  logic [XLEN-1:0] cap_result,
    input  logic [4:0]      cap_rs1,
    input  logic [4:0]      cap_rs2,
    input  logic [4:0]      cap_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [1:0]      state,
    output logic [AW:0]     entries,
    output logic            overflow
);

    localparam int          RW      = 2 * XLEN + 15;
    localparam logic [AW:0] FULL    = (AW + 1)'(DEPTH);
    localparam logic [AW:0] E_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0] P_ONE = AW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] post_left_q, post_left_d;
    logic [AW:0]   entries_q, entries_d;
    logic          overflow_q, overflow_d;

    logic [RW-1:0] mem [DEPTH];
    logic [RW-1:0] rd_rec;
    logic          wr_en;
    logic          pop;

    // A capture is only stored while armed or in the post window; arm discards it.
    assign wr_en = !rst && !arm && cap_valid && (state_q == ARMED || state_q == POST);
    assign pop   = out_valid && out_ready;

    // Next-state, pointer and counter logic.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        post_left_d = post_left_q;
        entries_d   = entries_q;
        overflow_d  = overflow_q;
        if (arm) begin
            wr_ptr_d    = '0;
            entries_d   = '0;
            overflow_d  = 1'b0;
            post_left_d = post_cnt;
            state_d     = ARMED;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + P_ONE;
                if (entries_q == FULL) begin
                    overflow_d = 1'b1;
                end else begin
                    entries_d = entries_q + E_ONE;
                end
            end
            case (state_q)
                ARMED: begin
                    if (cap_valid && cap_pc == trig_pc) begin
                        state_d = (post_left_q == '0) ? DONE : POST;
                    end
                end
                POST: begin
                    if (cap_valid) begin
                        post_left_d = post_left_q - P_ONE;
                        if (post_left_q == P_ONE) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (pop) begin
                        rd_ptr_d  = rd_ptr_q + P_ONE;
                        entries_d = entries_q - E_ONE;
                    end
                end
                default: ;
            endcase
            // Entering DONE: point at the oldest record. When full, the low
            // bits of entries are zero so the oldest sits at the write pointer.
            if (state_d == DONE && state_q != DONE) begin
                rd_ptr_d = wr_ptr_d - entries_d[AW-1:0];
            end
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            post_left_q <= '0;
            entries_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            post_left_q <= post_left_d;
            entries_q   <= entries_d;
            overflow_q  <= overflow_d;
        end
    end

    // Trace storage; never reset, only read at positions holding valid records.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {cap_pc, cap_result, cap_rs1, cap_rs2, cap_rd};
        end
    end

    assign rd_rec    = mem[rd_ptr_q];
    assign out_valid = (state_q == DONE) && (entries_q != '0);
    assign state     = state_q;
    assign entries   = entries_q;
    assign overflow  = overflow_q;

    // Readout fields are forced to zero whenever no record is offered.
    always_comb begin
        out_pc     = '0;
        out_result = '0;
        out_rs1    = '0;
        out_rs2    = '0;
        out_rd     = '0;
        if (out_valid) begin
            {out_pc, out_result, out_rs1, out_rs2, out_rd} = rd_rec;
        end
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb/tb_commit_trace_buffer.sv - randomized and directed checks of commit_trace_buffer against a queue model
module tb_commit_trace_buffer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic            clk = 1'b0;
    logic            rst, arm, cap_valid, out_ready, out_valid, overflow;
    logic [XLEN-1:0] trig_pc, cap_pc, cap_result, out_pc, out_result;
    logic [AW-1:0]   post_cnt;
    logic [4:0]      cap_rs1, cap_rs2, cap_rd, out_rs1, out_rs2, out_rd;
    logic [1:0]      state;
    logic [AW:0]     entries;

    always #5 clk = ~clk;

    commit_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .arm(arm), .trig_pc(trig_pc), .post_cnt(post_cnt),
        .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_result(cap_result),
        .cap_rs1(cap_rs1), .cap_rs2(cap_rs2), .cap_rd(cap_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_result(out_result), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .state(state), .entries(entries), .overflow(overflow)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] res;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } rec_t;

    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;

    // Reference model: a queue of retained records, oldest at index 0.
    int   m_state = 0;
    rec_t q[$];
    bit   m_ovf = 1'b0;
    int   m_left = 0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void push(rec_t r);
        q.push_back(r);
        if (q.size() > DEPTH) begin
            void'(q.pop_front());
            m_ovf = 1'b1;
        end
    endfunction

    function automatic void model_update();
        rec_t r;
        r = {cap_pc, cap_result, cap_rs1, cap_rs2, cap_rd};
        if (rst) begin
            m_state = 0;
            q.delete();
            m_ovf  = 1'b0;
            m_left = 0;
        end else if (arm) begin
            q.delete();
            m_ovf   = 1'b0;
            m_left  = int'(post_cnt);
            m_state = 1;
        end else begin
            case (m_state)
                1: if (cap_valid) begin
                    push(r);
                    if (cap_pc == trig_pc) m_state = (m_left == 0) ? 3 : 2;
                end
                2: if (cap_valid) begin
                    push(r);
                    m_left--;
                    if (m_left == 0) m_state = 3;
                end
                3: if (q.size() > 0 && out_ready) void'(q.pop_front());
                default: ;
            endcase
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic feed(input logic [31:0] pc);
        cap_valid  = 1'b1;
        cap_pc     = pc;
        cap_result = $urandom;
        cap_rs1    = 5'($urandom);
        cap_rs2    = 5'($urandom);
        cap_rd     = 5'($urandom);
        cyc();
        cap_valid  = 1'b0;
    endtask

    task automatic do_arm(input logic [31:0] tpc, input logic [AW-1:0] pc_cnt);
        trig_pc  = tpc;
        post_cnt = pc_cnt;
        arm      = 1'b1;
        cyc();
        arm      = 1'b0;
    endtask

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            rec_t e;
            bit   v;
            v = (m_state == 3) && (q.size() != 0);
            e = v ? q[0] : '0;
            chk("state", state, m_state);
            chk("entries", entries, q.size());
            chk("overflow", overflow, m_ovf);
            chk("out_valid", out_valid, v);
            chk("out_rec", {out_pc, out_result, out_rs1, out_rs2, out_rd}, e);
        end
    end

    initial begin
        rst = 1'b1; arm = 1'b0; trig_pc = '0; post_cnt = '0;
        cap_valid = 1'b0; cap_pc = '0; cap_result = '0;
        cap_rs1 = '0; cap_rs2 = '0; cap_rd = '0; out_ready = 1'b0;

        cyc();
        cmp_en = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_entries", entries, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);

        // Trigger at 0x0C with two post records; 0x18 arrives after DONE.
        do_arm(32'h0C, 4'd2);
        chk("arm_state", state, 1);
        for (int i = 0; i < 7; i++) begin
            feed(32'(4 * i));
            if (i == 4) chk("post_state", state, 2);
            if (i == 5) chk("done_after_14", state, 3);
        end
        chk("done_entries", entries, 6);
        chk("done_overflow", overflow, 0);

        // Back-pressure holds the head record, then drain in order.
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_pc", out_pc, 0);
            chk("hold_entries", entries, 6);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("drain_pc", out_pc, 4 * i);
            cyc();
        end
        out_ready = 1'b0;
        chk("drained_entries", entries, 0);
        chk("drained_valid", out_valid, 0);
        chk("drained_pc", out_pc, 0);

        // Wrap with overflow: last 16 of 20 records retained.
        do_arm(32'h4C, 4'd0);
        for (int i = 0; i < 20; i++) feed(32'(4 * i));
        chk("ovf_state", state, 3);
        chk("ovf_entries", entries, 16);
        chk("ovf_flag", overflow, 1);
        chk("ovf_first_pc", out_pc, 32'h10);
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) cyc();
        chk("ovf_last_pc", out_pc, 32'h4C);
        cyc();
        chk("ovf_empty", out_valid, 0);
        out_ready = 1'b0;

        // Invalid cycle carrying the trigger PC must not fire.
        do_arm(32'h08, 4'd3);
        cap_pc = 32'h08;
        cyc();
        chk("invalid_no_trig", state, 1);
        chk("invalid_no_write", entries, 0);
        feed(32'h00);
        feed(32'h08);
        chk("trig_post", state, 2);
        cyc();
        feed(32'h0C);
        chk("post1", state, 2);
        cap_pc = 32'h08;
        cyc();
        feed(32'h10);
        chk("post2", state, 2);
        feed(32'h14);
        chk("post3_done", state, 3);
        chk("post3_entries", entries, 5);

        // Re-arm mid POST.
        do_arm(32'h08, 4'd3);
        for (int i = 0; i < 5; i++) feed(32'(4 * i));
        chk("mid_post_state", state, 2);
        chk("mid_post_entries", entries, 5);
        do_arm(32'h08, 4'd3);
        chk("rearm_state", state, 1);
        chk("rearm_entries", entries, 0);

        // Reset mid POST, asserted together with arm and a capture.
        for (int i = 0; i < 5; i++) feed(32'(4 * i));
        chk("mid_post_state2", state, 2);
        rst = 1'b1; arm = 1'b1; cap_valid = 1'b1; cap_pc = 32'h08;
        cyc();
        rst = 1'b0; arm = 1'b0; cap_valid = 1'b0;
        chk("rst_prio_state", state, 0);
        chk("rst_prio_entries", entries, 0);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            arm = ($urandom_range(0, 49) == 0);
            if (arm) begin
                trig_pc  = 32'(4 * $urandom_range(0, 15));
                post_cnt = 4'($urandom_range(0, 15));
            end
            cap_valid  = ($urandom_range(0, 9) < 7);
            cap_pc     = 32'(4 * $urandom_range(0, 15));
            cap_result = $urandom;
            cap_rs1    = 5'($urandom);
            cap_rs2    = 5'($urandom);
            cap_rd     = 5'($urandom);
            out_ready  = 1'($urandom_range(0, 1));
            cyc();
        end
        rst = 1'b0; arm = 1'b0; cap_valid = 1'b0;
        cyc();

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 Parameter XLEN, default 32: width of the PC and result fields.
REQ-002 Parameter DEPTH, default 16: number of trace entries; SHALL be a power of two and at least 2.
REQ-003 Parameter AW, default $clog2(DEPTH): pointer width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 arm  in  1  pulse that clears the buffer and starts capture.
REQ-007 trig_pc  in  XLEN  PC value that fires the trigger.
REQ-008 post_cnt  in  AW  number of records captured after the trigger record; sampled on arm.
REQ-009 cap_valid  in  1  one committed instruction is presented this cycle.
REQ-010 cap_pc / cap_result  in  XLEN each  committed PC and ALU result.
REQ-011 cap_rs1 / cap_rs2 / cap_rd  in  5 each  register indices.
REQ-012 out_valid  out  1  readout record available.
REQ-013 out_ready  in  1  consumer accepts the readout record.
REQ-014 out_pc / out_result  out  XLEN each; out_rs1 / out_rs2 / out_rd  out  5 each; readout record fields.
REQ-015 state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE.
REQ-016 entries  out  AW+1  count of valid stored records.
REQ-017 overflow  out  1  at least one record was overwritten since the last arm.

Function
REQ-018 IDLE: no capture; out_valid=0.
REQ-019 arm=1 in any state, including ARMED or POST mid-capture, SHALL:
- set wr_ptr=0, entries=0, overflow=0;
- latch post_cnt into post_left;
- move to ARMED next cycle;
- discard any capture presented in the same cycle.
REQ-020 ARMED, cap_valid=1 SHALL:
- write the record at wr_ptr;
- advance wr_ptr modulo DEPTH;
- increment entries, saturating at DEPTH.
REQ-021 A write in ARMED while entries==DEPTH SHALL overwrite the oldest record and set overflow=1, which stays set until the next arm or rst.
REQ-022 ARMED, cap_valid=1 and cap_pc==trig_pc: the record SHALL be written, then the block moves to DONE if post_left==0, otherwise to POST.
- cap_valid=0 never triggers, whatever cap_pc is.
REQ-023 POST:
- each cap_valid=1 writes as in REQ-020/021 and decrements post_left;
- the write made with post_left==1 moves the block to DONE;
- cap_valid=0 cycles consume nothing;
- trig_pc matches are ignored.
REQ-024 Because post_cnt<=DEPTH-1, the trigger record SHALL always be retained at DONE.
REQ-025 On entering DONE, rd_ptr SHALL be set to (wr_ptr-entries) mod DEPTH (oldest record); no further capture occurs.
REQ-026 DONE: out_valid=(entries!=0), and out_* SHALL show the record at rd_ptr.
- on out_valid && out_ready: rd_ptr advances modulo DEPTH and entries decrements;
- records are delivered oldest first.
REQ-027 While out_valid=1 and out_ready=0, out_* SHALL hold stable.
REQ-028 When out_valid=0, all out_* fields SHALL read 0.
REQ-029 DONE with entries==0 SHALL remain in DONE until arm or rst.
REQ-030 The storage array needs no reset; no out_* value may depend on unwritten storage.

Reset
REQ-031 On rst=1 at a clock edge:
- state=IDLE;
- wr_ptr=0, rd_ptr=0, post_left=0;
- entries=0, overflow=0, out_valid=0;
- all out_* fields=0.
REQ-032 rst SHALL take priority over arm and cap_valid in the same cycle.
REQ-033 rst mid-POST or mid-readout SHALL discard all records.

Verification (DEPTH=16, XLEN=32)
REQ-034 Hold rst 2 cycles -> state=0, entries=0, overflow=0, out_valid=0, out_pc=0.
REQ-035 arm with trig_pc=0x0C, post_cnt=2; feed PCs 0x00..0x18 step 4 back to back -> state=3 after 0x14; entries=6; overflow=0; readout PCs 0x00,0x04,...,0x14 in order.
REQ-036 arm with post_cnt=0, trig_pc=0x4C; feed 20 records PC 0x00..0x4C -> entries=16, overflow=1, first out_pc=0x10, last out_pc=0x4C.
REQ-037 In DONE with entries=6, hold out_ready=0 for 3 cycles -> out_* unchanged and entries=6; then out_ready=1 for 6 cycles -> entries=0, out_valid=0.
REQ-038 trig_pc=0x08, post_cnt=3, with cap_valid=0 gaps and cap_pc=0x08 on a cap_valid=0 cycle -> no trigger on the invalid cycle; DONE only after the 3rd valid post-trigger write.
REQ-039 Two re-start checks, each from state=2 with entries=5:
- arm -> next cycle state=1, entries=0;
- rst -> state=0, entries=0.
